// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op and state encodings plus
// small helpers for op classification, alignment and store lane packing.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Loads occupy the low end of the encoding space.
    localparam lsu_op_e LAST_LOAD_OP = OP_LBU;

    function automatic logic is_load(lsu_op_e op);
        return op <= LAST_LOAD_OP;
    endfunction

    function automatic logic is_store(lsu_op_e op);
        return !is_load(op);
    endfunction

    function automatic logic misaligned(lsu_op_e op, logic [1:0] off);
        case (op)
            OP_LW, OP_SW:          return off != 2'b00;
            OP_LH, OP_LHU, OP_SH:  return off[0];
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(lsu_op_e op, logic [1:0] off);
        case (op)
            OP_SW:   return 4'b1111;
            OP_SH:   return 4'b0011 << off;
            OP_SB:   return 4'b0001 << off;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(lsu_op_e op, logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load lane select with sign/zero extension of a memory word.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{byte_off, 3'b000} +: 8];
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  data = {24'h0, lane_b};
            OP_LH:   data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  data = {16'h0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: checks alignment/range, drives a req/ack data
// memory port and returns extended load data or an address-error response.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_adel,
    output logic        resp_ades,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;

    lsu_op_e     req_op_e;
    logic [32:0] base_offset;
    logic        in_range;
    logic        req_err;
    logic [31:0] load_data;

    assign req_op_e = lsu_op_e'(req_op);

    // Subtracting the base in 33 bits makes "below base" show up as a borrow,
    // so one unsigned compare against the size covers both bounds.
    assign base_offset = {1'b0, req_addr} - {1'b0, DM_BASE};
    assign in_range    = !base_offset[32] && (base_offset[31:0] < DM_SIZE);
    assign req_err     = !in_range || misaligned(req_op_e, req_addr[1:0]);

    lsu_load_extract u_extract (
        .op       (op_q),
        .byte_off (off_q),
        .word     (mem_rdata),
        .data     (load_data)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case can infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        adel_d       = adel_q;
        ades_d       = ades_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d         = req_op_e;
                    off_d        = req_addr[1:0];
                    resp_rdata_d = 32'h0;
                    if (req_err) begin
                        state_d = ST_RESP;
                        adel_d  = is_load(req_op_e);
                        ades_d  = is_store(req_op_e);
                    end else begin
                        state_d     = ST_MEM;
                        mem_we_d    = is_store(req_op_e);
                        mem_be_d    = store_be(req_op_e, req_addr[1:0]);
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = store_lanes(req_op_e, req_wdata);
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (is_load(op_q)) begin
                        resp_rdata_d = load_data;
                    end
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_rdata_d = 32'h0;
                adel_d       = 1'b0;
                ades_d       = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LW;
            off_q        <= 2'b00;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values together.
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            adel_q       <= adel_d;
            ades_q       <= ades_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_req    = (state_q == ST_MEM);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_adel  = adel_q;
    assign resp_ades  = ades_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: expected responses are queued when a
// request is driven and compared when resp_valid appears.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_adel;
    logic        resp_ades;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                           LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    always #5 clk = ~clk;

    lsu_mem_access dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_adel  (resp_adel),
        .resp_ades  (resp_ades),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(logic [2:0] op, logic [1:0] off, logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (op)
            LB:      return 32'($signed(sh[7:0]));
            LBU:     return sh & 32'h0000_00FF;
            LH:      return 32'($signed(sh[15:0]));
            LHU:     return sh & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // Drives one request from IDLE, plays the memory with `waits` wait
    // states, and checks the port and the response cycle by cycle.
    task automatic access(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word,
                          input int waits, input logic err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input exp_t exp_resp, input string name);
        exp_t got;
        logic is_st;
        is_st = op >= SW;
        sb_q.push_back(exp_resp);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready); end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        if (!err) begin
            for (int i = 0; i <= waits; i++) begin
                total++;
                if (mem_req !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                    bad++; $display("FAIL %s mem_cycle%0d ctrl: got req=%b ready=%b rv=%b want 1 0 0", name, i, mem_req, req_ready, resp_valid);
                end
                total++;
                if (mem_we !== is_st || mem_be !== exp_be || mem_addr !== (addr & ~32'h3)) begin
                    bad++; $display("FAIL %s mem_cycle%0d port: got we=%b be=%b addr=%h want we=%b be=%b addr=%h",
                                    name, i, mem_we, mem_be, mem_addr, is_st, exp_be, addr & ~32'h3);
                end
                if (is_st) begin
                    total++;
                    if (mem_wdata !== exp_wdata) begin bad++; $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, exp_wdata); end
                end
                mem_ack   = (i == waits);
                mem_rdata = (i == waits) ? word : ~word;
                step();
            end
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
        end
        total++;
        if (resp_valid !== 1'b1 || mem_req !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL %s resp_cycle: got rv=%b req=%b ready=%b want 1 0 0", name, resp_valid, mem_req, req_ready);
        end
        if (resp_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++; $display("FAIL %s scoreboard: got response want none pending", name);
            end else begin
                got = sb_q.pop_front();
                if (resp_rdata !== got.rdata || resp_adel !== got.adel || resp_ades !== got.ades) begin
                    bad++; $display("FAIL %s resp_data: got rdata=%h adel=%b ades=%b want rdata=%h adel=%b ades=%b",
                                    name, resp_rdata, resp_adel, resp_ades, got.rdata, got.adel, got.ades);
                end
            end
        end else begin
            void'(sb_q.pop_front());
        end
        step();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL %s after_resp: got rv=%b ready=%b req=%b want 0 1 0", name, resp_valid, req_ready, mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) step();
        reset = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got ready=%b rv=%b req=%b we=%b want 1 0 0 0", req_ready, resp_valid, mem_req, mem_we);
        end
        total++;
        if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 ||
            resp_adel !== 1'b0 || resp_ades !== 1'b0) begin
            bad++; $display("FAIL reset_data: got be=%h addr=%h wd=%h rd=%h adel=%b ades=%b want all 0",
                            mem_be, mem_addr, mem_wdata, resp_rdata, resp_adel, resp_ades);
        end
    endtask

    task automatic test_loads();
        access(LW,  32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'b0000, 32'h0, '{32'hDEADBEEF, 1'b0, 1'b0}, "lw");
        access(LB,  32'h13, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, '{32'hFFFFFF80, 1'b0, 1'b0}, "lb");
        access(LBU, 32'h13, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, '{32'h00000080, 1'b0, 1'b0}, "lbu");
        access(LH,  32'h12, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, '{32'hFFFF80FF, 1'b0, 1'b0}, "lh");
        access(LHU, 32'h12, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, '{32'h000080FF, 1'b0, 1'b0}, "lhu");
        access(LB,  32'h11, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, '{32'h00000012, 1'b0, 1'b0}, "lb_pos");
        access(LH,  32'h10, 32'h0, 32'h80FF9234, 0, 1'b0, 4'b0000, 32'h0, '{32'hFFFF9234, 1'b0, 1'b0}, "lh_low");
        access(LW,  32'h2FFC, 32'h0, 32'h01234567, 0, 1'b0, 4'b0000, 32'h0, '{32'h01234567, 1'b0, 1'b0}, "lw_top");
    endtask

    task automatic test_stores();
        access(SB, 32'h21, 32'h123456AB, 32'h0, 0, 1'b0, 4'b0010, 32'hABABABAB, '{32'h0, 1'b0, 1'b0}, "sb");
        access(SH, 32'h22, 32'h123456AB, 32'h0, 0, 1'b0, 4'b1100, 32'h56AB56AB, '{32'h0, 1'b0, 1'b0}, "sh");
        access(SH, 32'h20, 32'h9999CDEF, 32'h0, 0, 1'b0, 4'b0011, 32'hCDEFCDEF, '{32'h0, 1'b0, 1'b0}, "sh_low");
        access(SW, 32'h24, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1'b0, 4'b1111, 32'hCAFEF00D, '{32'h0, 1'b0, 1'b0}, "sw");
        access(SB, 32'h2FFF, 32'h00000011, 32'h0, 0, 1'b0, 4'b1000, 32'h11111111, '{32'h0, 1'b0, 1'b0}, "sb_top");
    endtask

    task automatic test_errors();
        access(LH, 32'h11,   32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, '{32'h0, 1'b1, 1'b0}, "lh_misalign");
        access(LW, 32'h12,   32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, '{32'h0, 1'b1, 1'b0}, "lw_misalign");
        access(SW, 32'h3000, 32'h5, 32'h0, 0, 1'b1, 4'b0000, 32'h0, '{32'h0, 1'b0, 1'b1}, "sw_range");
        access(SH, 32'h33,   32'h5, 32'h0, 0, 1'b1, 4'b0000, 32'h0, '{32'h0, 1'b0, 1'b1}, "sh_misalign");
        access(LB, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, '{32'h0, 1'b1, 1'b0}, "lb_range");
    endtask

    task automatic test_wait_states();
        access(SW, 32'h40, 32'h0BADF00D, 32'h0, 3, 1'b0, 4'b1111, 32'h0BADF00D, '{32'h0, 1'b0, 1'b0}, "sw_wait3");
        access(LHU, 32'h46, 32'h0, 32'hBEEF0001, 2, 1'b0, 4'b0000, 32'h0, '{32'h0000BEEF, 1'b0, 1'b0}, "lhu_wait2");
    endtask

    task automatic test_reset_in_mem();
        req_valid = 1'b1; req_op = LW; req_addr = 32'h50;
        step();
        req_valid = 1'b0;
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mem entered: got req=%b want 1", mem_req); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rst_mem after: got req=%b ready=%b rv=%b be=%h addr=%h want 0 1 0 0 0",
                            mem_req, req_ready, resp_valid, mem_be, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_mem stray_ack: got rv=%b ready=%b req=%b want 0 1 0", resp_valid, req_ready, mem_req);
        end
        access(LW, 32'h50, 32'h0, 32'h13572468, 1, 1'b0, 4'b0000, 32'h0, '{32'h13572468, 1'b0, 1'b0}, "lw_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] addr, word;
        for (int n = 0; n < 24; n++) begin
            op   = 3'($urandom_range(0, 4));
            addr = $urandom_range(0, 32'h2FFF);
            if (op == LW) addr = addr & ~32'h3;
            else if (op == LH || op == LHU) addr = addr & ~32'h1;
            word = $urandom;
            access(op, addr, 32'h0, word, int'($urandom_range(0, 2)), 1'b0, 4'b0000, 32'h0,
                   '{ref_load(op, addr[1:0], word), 1'b0, 1'b0}, "rand_load");
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_wait_states();
        test_reset_in_mem();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Multi-cycle load/store unit between the MEM pipeline stage and data memory.
- Immediate extension widens instruction fields into datapath values. This block handles the memory data path in both directions:
  - loads: takes raw memory words and produces sign- or zero-extended byte, half or word results;
  - stores: packs register data into byte lanes with byte enables.
- Checks alignment and address range, raises address-error flags, and runs a request/ack handshake to a memory that may wait-state.

Parameters:
- DM_BASE, 32'h0000_0000, lowest legal data address.
- DM_SIZE, 32'h0000_3000, legal byte span; addresses in [DM_BASE, DM_BASE+DM_SIZE) are valid.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents an access.
- req_op  in  3  access type (package encoding).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low bits used for SB/SH).
- req_ready  out  1  unit idle, can accept.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_adel  out  1  load address error, valid with resp_valid.
- resp_ades  out  1  store address error, valid with resp_valid.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables; bit i = byte lane i (little-endian).
- mem_addr  out  32  word address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completes the request this cycle; rdata valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; adel=ades=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0.
- States: IDLE, MEM, RESP.
- IDLE
  - req_ready=1.
  - When req_valid=1, latch op/addr/wdata.
  - Error checks:
    - misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0;
    - out of range: addr outside [DM_BASE, DM_BASE+DM_SIZE).
  - On error: go RESP with adel (load) or ades (store) set. No mem_req is issued.
  - Otherwise: go MEM.
- MEM
  - mem_req=1. mem_we, mem_be, mem_addr and mem_wdata are stable from registered values until ack.
  - Byte enables: SW be=4'b1111. SH be=4'b0011<<addr[1:0] (so 0011 or 1100). SB be=4'b0001<<addr[1:0]. Loads be=4'b0000.
  - Store data lanes: SB wdata={4{d[7:0]}}. SH wdata={2{d[15:0]}}. SW wdata=d.
  - On mem_ack=1: for loads, capture the selected lane of mem_rdata and extend:
    - LB: sign-extend byte.
    - LBU: zero-extend byte.
    - LH: sign-extend half.
    - LHU: zero-extend half.
    - LW: whole word.
  - After ack, go RESP. mem_req drops in the same transition, so it is 0 in the RESP cycle.
- RESP
  - resp_valid=1 for exactly one cycle; then return to IDLE.
  - req_ready=0 in MEM and RESP.
- Latency:
  - request accepted at cycle T; mem_req first high at T+1;
  - with ack at T+1, resp_valid at T+2;
  - each wait cycle adds 1;
  - an error request gets resp_valid at T+1.
- Robustness:
  - mem_ack outside MEM is ignored.
  - req_valid outside IDLE is ignored; the requester holds until req_ready.
- Reset in any state: next cycle is IDLE with all outputs at reset values. An in-flight mem_req is abandoned and the memory must tolerate this.
- Range check uses unsigned 32-bit compare; the end bound is computed without overflow (DM_BASE+DM_SIZE must fit in 32 bits).

Decomposition:
- Shared package lsu_pkg:
  - op encodings: LW=3'b000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111;
  - state encoding;
  - is_load/is_store helper constants.
- One natural sub-module, lsu_load_extract: combinational lane select plus sign/zero extend from (op, addr[1:0], word). It is testable standalone.

Test Plan:
- LW addr=0x10, mem_rdata=0xDEADBEEF, ack on first MEM cycle -> mem_req at T+1, be=0000, resp_valid at T+2, rdata=0xDEADBEEF.
- LB addr=0x13, mem_rdata=0x80FF_1234 -> rdata=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x12 -> 0xFFFF80FF. LHU -> 0x000080FF.
- SB addr=0x21, wdata=0x123456AB -> mem_we=1, be=0010, mem_addr=0x20, mem_wdata=0xABABABAB. SH addr=0x22 -> be=1100, wdata=0x56AB56AB.
- LH addr=0x11 -> resp_valid at T+1 with adel=1, mem_req never asserted. SW addr=0x3000 (out of range) -> ades=1.
- mem_ack delayed 3 cycles -> mem_req/be/addr held stable for 3 cycles, req_ready=0 throughout, resp_valid one cycle after ack.
- reset asserted while in MEM -> next cycle mem_req=0, req_ready=1, no resp_valid. A later mem_ack is ignored. A new LW completes normally.
